// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM operand forwarding,
// load-use hazard detection (one bubble per hazard) and a bubble counter.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   id_*              decoded instruction and register file read data from ID
//   ex_result         ALU result of the instruction currently in EX
//   mem_*             MEM stage destination and writeback value
//   flush, ex_hold    squash the incoming instruction / freeze the stage
//   hazard_stall      comb load-use detect; freezes PC and IF/ID upstream
//   ex_*              latched EX operands and control
//   stall_count       saturating count of bubbles inserted
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_aluOp,
    input  logic [TAG_W-1:0]  id_rs_tag,
    input  logic [TAG_W-1:0]  id_rt_tag,
    input  logic              id_useRs,
    input  logic              id_useRt,
    input  logic              id_useImm,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [TAG_W-1:0]  id_rd_tag,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_regWrite,
    input  logic [TAG_W-1:0]  mem_rd_tag,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [OP_W-1:0]   ex_aluOp,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [DATA_W-1:0] ex_storeData,
    output logic [TAG_W-1:0]  ex_rd_tag,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   aluOp;
        logic [DATA_W-1:0] opA;
        logic [DATA_W-1:0] opB;
        logic [DATA_W-1:0] storeData;
        logic [TAG_W-1:0]  rdTag;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
    } exBundle_t;

    exBundle_t        exQ;
    exBundle_t        exD;
    logic [CNT_W-1:0] stallCnt;

    logic              exFwdOk;
    logic              memFwdOk;
    logic              exLoad;
    logic              rsExHit;
    logic              rtExHit;
    logic              rsMemHit;
    logic              rtMemHit;
    logic [DATA_W-1:0] fwdRs;
    logic [DATA_W-1:0] fwdRt;

    // A load in EX has no value yet; it is handled by the stall instead.
    assign exFwdOk  = exQ.valid & exQ.regWrite & ~exQ.memRead;
    assign memFwdOk = mem_valid & mem_regWrite;
    assign exLoad   = exQ.valid & exQ.memRead & exQ.regWrite;

    assign rsExHit  = exFwdOk & (id_rs_tag == exQ.rdTag);
    assign rtExHit  = exFwdOk & (id_rt_tag == exQ.rdTag);
    assign rsMemHit = memFwdOk & (id_rs_tag == mem_rd_tag);
    assign rtMemHit = memFwdOk & (id_rt_tag == mem_rd_tag);

    // WB needs no path: the register file writes on negedge.
    assign fwdRs = rsExHit  ? ex_result  :
                   rsMemHit ? mem_result : id_data1;
    assign fwdRt = rtExHit  ? ex_result  :
                   rtMemHit ? mem_result : id_data2;

    assign hazard_stall = id_valid & exLoad &
        ((id_useRs & (id_rs_tag == exQ.rdTag)) |
         (id_useRt & (id_rt_tag == exQ.rdTag)));

    always_comb begin
        exD           = '0;
        exD.valid     = id_valid;
        exD.aluOp     = id_aluOp;
        exD.opA       = fwdRs;
        exD.opB       = id_useImm ? id_imm : fwdRt;
        exD.storeData = fwdRt;
        exD.rdTag     = id_rd_tag;
        exD.regWrite  = id_valid & id_regWrite;
        exD.memRead   = id_valid & id_memRead;
        exD.memWrite  = id_valid & id_memWrite;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            exQ      <= '0;
            stallCnt <= '0;
        end else if (flush) begin
            exQ.valid    <= 1'b0;
            exQ.regWrite <= 1'b0;
            exQ.memRead  <= 1'b0;
            exQ.memWrite <= 1'b0;
        end else if (!ex_hold) begin
            if (hazard_stall) begin
                exQ.valid    <= 1'b0;
                exQ.regWrite <= 1'b0;
                exQ.memRead  <= 1'b0;
                exQ.memWrite <= 1'b0;
                if (stallCnt != '1) begin
                    stallCnt <= stallCnt + CNT_W'(1);
                end
            end else begin
                exQ <= exD;
            end
        end
    end

    assign ex_valid     = exQ.valid;
    assign ex_aluOp     = exQ.aluOp;
    assign ex_opA       = exQ.opA;
    assign ex_opB       = exQ.opB;
    assign ex_storeData = exQ.storeData;
    assign ex_rd_tag    = exQ.rdTag;
    assign ex_regWrite  = exQ.regWrite;
    assign ex_memRead   = exQ.memRead;
    assign ex_memWrite  = exQ.memWrite;
    assign stall_count  = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage
// against a cycle-level reference model of the ID/EX stage.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid, id_useRs, id_useRt, id_useImm;
    logic [3:0]  id_aluOp, id_rs_tag, id_rt_tag, id_rd_tag;
    logic [15:0] id_data1, id_data2, id_imm;
    logic        id_regWrite, id_memRead, id_memWrite;
    logic [15:0] ex_result, mem_result;
    logic        mem_valid, mem_regWrite;
    logic [3:0]  mem_rd_tag;
    logic        flush, ex_hold;

    logic        hazard_stall, ex_valid;
    logic [3:0]  ex_aluOp, ex_rd_tag;
    logic [15:0] ex_opA, ex_opB, ex_storeData;
    logic        ex_regWrite, ex_memRead, ex_memWrite;
    logic [15:0] stall_count;

    logic        sHazard, sValid;
    logic [3:0]  sAluOp, sRd;
    logic [15:0] sOpA, sOpB, sStore;
    logic        sRw, sMr, sMw;
    logic [3:0]  sCount;

    int compared = 0;
    int mismatched = 0;

    always #5 CLK = ~CLK;

    id_ex_stage dut (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_aluOp(id_aluOp),
        .id_rs_tag(id_rs_tag), .id_rt_tag(id_rt_tag),
        .id_useRs(id_useRs), .id_useRt(id_useRt),
        .id_useImm(id_useImm),
        .id_data1(id_data1), .id_data2(id_data2),
        .id_imm(id_imm), .id_rd_tag(id_rd_tag),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite),
        .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_regWrite(mem_regWrite),
        .mem_rd_tag(mem_rd_tag), .mem_result(mem_result),
        .flush(flush), .ex_hold(ex_hold),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .ex_aluOp(ex_aluOp), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_storeData(ex_storeData), .ex_rd_tag(ex_rd_tag),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    id_ex_stage #(.CNT_W(4)) dutSat (
        .CLK(CLK), .RST(RST),
        .id_valid(id_valid), .id_aluOp(id_aluOp),
        .id_rs_tag(id_rs_tag), .id_rt_tag(id_rt_tag),
        .id_useRs(id_useRs), .id_useRt(id_useRt),
        .id_useImm(id_useImm),
        .id_data1(id_data1), .id_data2(id_data2),
        .id_imm(id_imm), .id_rd_tag(id_rd_tag),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite),
        .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_regWrite(mem_regWrite),
        .mem_rd_tag(mem_rd_tag), .mem_result(mem_result),
        .flush(flush), .ex_hold(ex_hold),
        .hazard_stall(sHazard), .ex_valid(sValid),
        .ex_aluOp(sAluOp), .ex_opA(sOpA), .ex_opB(sOpB),
        .ex_storeData(sStore), .ex_rd_tag(sRd),
        .ex_regWrite(sRw), .ex_memRead(sMr),
        .ex_memWrite(sMw), .stall_count(sCount)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearIn();
        id_valid = 0; id_aluOp = 0; id_useRs = 0; id_useRt = 0;
        id_useImm = 0; id_rs_tag = 0; id_rt_tag = 0; id_rd_tag = 0;
        id_data1 = 0; id_data2 = 0; id_imm = 0;
        id_regWrite = 0; id_memRead = 0; id_memWrite = 0;
        ex_result = 0; mem_valid = 0; mem_regWrite = 0;
        mem_rd_tag = 0; mem_result = 0; flush = 0; ex_hold = 0;
    endtask

    task automatic doReset();
        clearIn();
        RST = 1;
        tick();
        tick();
        RST = 0;
    endtask

    // Load SP <- mem[R2 + 4]
    task automatic issueLoad();
        clearIn();
        id_valid = 1; id_aluOp = 4'd2;
        id_rs_tag = 4'd2; id_useRs = 1; id_data1 = 16'h0042;
        id_useImm = 1; id_imm = 16'h0004;
        id_rd_tag = 4'b1001; id_regWrite = 1; id_memRead = 1;
        tick();
    endtask

    // R4 <- SP op R3 (uses SP as rs)
    task automatic setUser();
        id_memRead = 0; id_useImm = 0;
        id_rs_tag = 4'b1001; id_useRs = 1; id_data1 = 16'h0000;
        id_rt_tag = 4'd3; id_useRt = 0; id_data2 = 16'h0303;
        id_rd_tag = 4'd4; id_aluOp = 4'd1; id_regWrite = 1;
    endtask

    task automatic test_reset();
        clearIn();
        id_valid = 1; id_aluOp = 4'd5; id_useRs = 1;
        id_data1 = 16'hAAAA; id_data2 = 16'h5555;
        id_rd_tag = 4'd6; id_regWrite = 1; id_memRead = 1;
        RST = 1;
        tick();
        tick();
        compared++;
        if ({ex_valid, ex_aluOp, ex_opA, ex_opB, ex_storeData, ex_rd_tag,
             ex_regWrite, ex_memRead, ex_memWrite} !== '0) begin
            mismatched++;
            $display("FAIL reset_regs: got %b %h %h %h %h %h %b%b%b want all 0",
                     ex_valid, ex_aluOp, ex_opA, ex_opB, ex_storeData,
                     ex_rd_tag, ex_regWrite, ex_memRead, ex_memWrite);
        end
        compared++;
        if (stall_count !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_count: got %h want 0000", stall_count);
        end
        compared++;
        if (hazard_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hazard: got %b want 0", hazard_stall);
        end
        RST = 0;
    endtask

    task automatic test_forward_priority();
        doReset();
        id_valid = 1; id_aluOp = 4'd1; id_rs_tag = 4'd1; id_useRs = 1;
        id_data1 = 16'h0010; id_rd_tag = 4'd3; id_regWrite = 1;
        tick();
        ex_result = 16'h1234; id_rs_tag = 4'd3; id_data1 = 16'h0000;
        id_rt_tag = 4'd4; id_useRt = 1; id_data2 = 16'h7777;
        #1;
        compared++;
        if (hazard_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL alu_no_hazard: got %b want 0", hazard_stall);
        end
        tick();
        compared++;
        if ({ex_valid, ex_opA, ex_opB, ex_storeData} !==
            {1'b1, 16'h1234, 16'h7777, 16'h7777}) begin
            mismatched++;
            $display("FAIL ex_fwd: got %b %h %h %h want 1 1234 7777 7777",
                     ex_valid, ex_opA, ex_opB, ex_storeData);
        end
        mem_valid = 1; mem_regWrite = 1; mem_rd_tag = 4'd3;
        mem_result = 16'h5555; id_rt_tag = 4'd3;
        id_useImm = 1; id_imm = 16'h00AB; id_rd_tag = 4'd7;
        tick();
        compared++;
        if ({ex_opA, ex_opB, ex_storeData, ex_rd_tag} !==
            {16'h1234, 16'h00AB, 16'h1234, 4'd7}) begin
            mismatched++;
            $display("FAIL ex_over_mem: got %h %h %h %h want 1234 00ab 1234 7",
                     ex_opA, ex_opB, ex_storeData, ex_rd_tag);
        end
        ex_result = 16'h9999; id_useImm = 0;
        tick();
        compared++;
        if ({ex_opA, ex_opB} !== {16'h5555, 16'h5555}) begin
            mismatched++;
            $display("FAIL mem_fwd: got %h %h want 5555 5555",
                     ex_opA, ex_opB);
        end
        id_valid = 0;
        tick();
        compared++;
        if ({ex_valid, ex_regWrite} !== 2'b00) begin
            mismatched++;
            $display("FAIL invalid_gate: got %b%b want 00",
                     ex_valid, ex_regWrite);
        end
    endtask

    task automatic test_load_use();
        doReset();
        issueLoad();
        setUser();
        #1;
        compared++;
        if (hazard_stall !== 1'b1) begin
            mismatched++;
            $display("FAIL lu_hazard: got %b want 1", hazard_stall);
        end
        tick();
        compared++;
        if ({ex_valid, ex_regWrite, ex_memRead, ex_memWrite, stall_count} !==
            {4'b0000, 16'd1}) begin
            mismatched++;
            $display("FAIL lu_bubble: got %b%b%b%b cnt %h want 0000 cnt 0001",
                     ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
                     stall_count);
        end
        mem_valid = 1; mem_regWrite = 1; mem_rd_tag = 4'b1001;
        mem_result = 16'hBEEF;
        #1;
        compared++;
        if (hazard_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL lu_clear: got %b want 0", hazard_stall);
        end
        tick();
        compared++;
        if ({ex_valid, ex_opA, ex_aluOp, ex_rd_tag, stall_count} !==
            {1'b1, 16'hBEEF, 4'd1, 4'd4, 16'd1}) begin
            mismatched++;
            $display("FAIL lu_fwd: got %b %h %h %h %h want 1 beef 1 4 0001",
                     ex_valid, ex_opA, ex_aluOp, ex_rd_tag, stall_count);
        end
    endtask

    task automatic test_hold();
        doReset();
        issueLoad();
        setUser();
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if ({ex_valid, ex_memRead, ex_regWrite, ex_rd_tag, ex_opA,
                 hazard_stall, stall_count} !==
                {3'b111, 4'b1001, 16'h0042, 1'b1, 16'd0}) begin
                mismatched++;
                $display("FAIL hold_%0d: got %b%b%b %h %h %b %h want 111 9 0042 1 0000",
                         i, ex_valid, ex_memRead, ex_regWrite, ex_rd_tag,
                         ex_opA, hazard_stall, stall_count);
            end
        end
        ex_hold = 0;
        tick();
        compared++;
        if ({ex_valid, stall_count} !== {1'b0, 16'd1}) begin
            mismatched++;
            $display("FAIL hold_release: got %b %h want 0 0001",
                     ex_valid, stall_count);
        end
        mem_valid = 1; mem_regWrite = 1; mem_rd_tag = 4'b1001;
        mem_result = 16'hC0DE;
        tick();
        compared++;
        if ({ex_valid, ex_opA, stall_count} !== {1'b1, 16'hC0DE, 16'd1}) begin
            mismatched++;
            $display("FAIL hold_load: got %b %h %h want 1 c0de 0001",
                     ex_valid, ex_opA, stall_count);
        end
    endtask

    task automatic test_flush_combo();
        doReset();
        issueLoad();
        setUser();
        flush = 1; ex_hold = 1;
        #1;
        compared++;
        if (hazard_stall !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_hazard: got %b want 1", hazard_stall);
        end
        tick();
        compared++;
        if ({ex_valid, ex_regWrite, ex_memRead, ex_memWrite, stall_count} !==
            {4'b0000, 16'd0}) begin
            mismatched++;
            $display("FAIL flush: got %b%b%b%b %h want 0000 0000",
                     ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
                     stall_count);
        end
        flush = 0; ex_hold = 0; id_data1 = 16'h0BAD;
        tick();
        compared++;
        if ({ex_valid, ex_opA, ex_regWrite} !== {1'b1, 16'h0BAD, 1'b1}) begin
            mismatched++;
            $display("FAIL flush_after: got %b %h %b want 1 0bad 1",
                     ex_valid, ex_opA, ex_regWrite);
        end
    endtask

    task automatic test_saturation();
        int want;
        doReset();
        for (int i = 0; i < 17; i++) begin
            issueLoad();
            setUser();
            tick();
            want = (i + 1 > 15) ? 15 : i + 1;
            compared++;
            if (sCount !== 4'(want)) begin
                mismatched++;
                $display("FAIL sat_%0d: got %0d want %0d", i, sCount, want);
            end
        end
        compared++;
        if (stall_count !== 16'd17) begin
            mismatched++;
            $display("FAIL wide_count: got %0d want 17", stall_count);
        end
    endtask

    // Reference model of the EX register contents.
    bit          mV, mRw, mMr, mMw, mKnown;
    logic [3:0]  mOp, mRd;
    logic [15:0] mA, mB, mSd;
    int          mCnt;

    function automatic logic [15:0] operand(input logic [3:0] tag,
                                            input logic [15:0] rf);
        if (mV && mRw && !mMr && tag == mRd) return ex_result;
        if (mem_valid && mem_regWrite && tag == mem_rd_tag) return mem_result;
        return rf;
    endfunction

    function automatic logic [3:0] pickTag();
        case ($urandom_range(0, 5))
            0: return 4'd0;
            1: return 4'd3;
            2: return 4'b1001;
            3: return 4'b1010;
            4: return 4'b1011;
            default: return 4'd5;
        endcase
    endfunction

    task automatic test_random();
        bit expHaz;
        logic [15:0] a, b;
        doReset();
        mV = 0; mRw = 0; mMr = 0; mMw = 0; mKnown = 1;
        mOp = 0; mRd = 0; mA = 0; mB = 0; mSd = 0; mCnt = 0;
        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            id_aluOp = 4'($urandom);
            id_rs_tag = pickTag(); id_rt_tag = pickTag();
            id_rd_tag = pickTag();
            id_useRs = 1'($urandom); id_useRt = 1'($urandom);
            id_useImm = 1'($urandom);
            id_data1 = 16'($urandom); id_data2 = 16'($urandom);
            id_imm = 16'($urandom);
            id_regWrite = ($urandom_range(0, 3) != 0);
            id_memRead = ($urandom_range(0, 2) == 0);
            id_memWrite = ($urandom_range(0, 7) == 0);
            ex_result = 16'($urandom);
            mem_valid = 1'($urandom); mem_regWrite = 1'($urandom);
            mem_rd_tag = pickTag(); mem_result = 16'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            #1;
            expHaz = id_valid && mV && mMr && mRw &&
                     ((id_useRs && id_rs_tag == mRd) ||
                      (id_useRt && id_rt_tag == mRd));
            compared++;
            if (hazard_stall !== expHaz) begin
                mismatched++;
                $display("FAIL rnd_hazard_%0d: got %b want %b",
                         i, hazard_stall, expHaz);
            end
            a = operand(id_rs_tag, id_data1);
            b = operand(id_rt_tag, id_data2);
            if (flush) begin
                mV = 0; mRw = 0; mMr = 0; mMw = 0; mKnown = 0;
            end else if (ex_hold) begin
                mV = mV;
            end else if (expHaz) begin
                mV = 0; mRw = 0; mMr = 0; mMw = 0; mKnown = 0;
                if (mCnt < 65535) mCnt++;
            end else begin
                mV = id_valid; mOp = id_aluOp; mRd = id_rd_tag;
                mA = a; mB = id_useImm ? id_imm : b; mSd = b;
                mRw = id_valid && id_regWrite;
                mMr = id_valid && id_memRead;
                mMw = id_valid && id_memWrite;
                mKnown = 1;
            end
            tick();
            compared++;
            if ({ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
                 stall_count} !== {mV, mRw, mMr, mMw, 16'(mCnt)}) begin
                mismatched++;
                $display("FAIL rnd_ctrl_%0d: got %b%b%b%b %0d want %b%b%b%b %0d",
                         i, ex_valid, ex_regWrite, ex_memRead, ex_memWrite,
                         stall_count, mV, mRw, mMr, mMw, mCnt);
            end
            if (mKnown) begin
                compared++;
                if ({ex_aluOp, ex_rd_tag, ex_opA, ex_opB, ex_storeData} !==
                    {mOp, mRd, mA, mB, mSd}) begin
                    mismatched++;
                    $display("FAIL rnd_data_%0d: got %h %h %h %h %h want %h %h %h %h %h",
                             i, ex_aluOp, ex_rd_tag, ex_opA, ex_opB,
                             ex_storeData, mOp, mRd, mA, mB, mSd);
                end
            end
        end
    endtask

    initial begin
        RST = 1;
        clearIn();
        test_reset();
        test_forward_priority();
        test_load_use();
        test_hold();
        test_flush_combo();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
